// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision constants, state/class enums and classifier
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, ROUND, DONE} state_t;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_t;

  // Subnormals classify as ZERO, which flushes them to a signed zero.
  function automatic cls_t classify(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != '0) ? NAN : INF;
    else if (x[30:23] == 8'h00) return ZERO;
    else return NORM;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - normalise, round-to-nearest-even and pack a 48-bit mantissa product
module fp_round_pack
  import fp_pkg::*;
(
  input  logic        sign,
  input  logic [9:0]  exp_in,
  input  logic [47:0] prod,
  input  logic [1:0]  cls,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        exception
);

  logic [46:0]       norm;
  logic signed [9:0] exp_a;
  logic signed [9:0] exp_r;
  logic              guard;
  logic              sticky;
  logic [24:0]       mant;
  logic [22:0]       frac;

  always_comb begin
    norm   = prod[47] ? prod[47:1] : prod[46:0];
    exp_a  = prod[47] ? $signed(exp_in) + 10'sd1 : $signed(exp_in);
    guard  = norm[22];
    sticky = (|norm[21:0]) | (prod[47] & prod[0]);
    mant   = {1'b0, norm[46:23]} + 25'(guard & (sticky | norm[23]));
    // A rounding carry-out leaves 1.000..0, so the fraction is the upper bits shifted once.
    exp_r  = mant[24] ? exp_a + 10'sd1 : exp_a;
    frac   = mant[24] ? mant[23:1] : mant[22:0];

    result    = {sign, exp_r[7:0], frac};
    overflow  = 1'b0;
    underflow = 1'b0;
    exception = 1'b0;

    case (cls)
      NAN: begin
        result    = QNAN;
        exception = 1'b1;
      end
      INF: begin
        result    = {sign, POS_INF[30:0]};
        exception = 1'b1;
      end
      ZERO: result = {sign, 31'h0};
      default: begin
        if (exp_r >= 10'sd255) begin
          result   = {sign, POS_INF[30:0]};
          overflow = 1'b1;
        end else if (exp_r <= 10'sd0) begin
          result    = {sign, 31'h0};
          underflow = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_seq_multiplier.sv
// rtl/fp_seq_multiplier.sv - multi-cycle shift-add IEEE single multiplier; FPMUL_EARLY_SPECIAL_EN skips MUL for special operands
module fp_seq_multiplier
  import fp_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        exception
);

  localparam int         N    = 24 / RADIX_BITS;
  localparam logic [4:0] LAST = 5'(N - 1);

  state_t      state;
  logic [31:0] a_r, b_r;
  logic        sign_r;
  logic [9:0]  exp_r;
  logic [1:0]  cls_r;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] acc, acc_nx;
  logic [4:0]  cnt;
  logic [31:0] pend_res, pack_res;
  logic        pend_ovf, pend_unf, pend_exc;
  logic        pack_ovf, pack_unf, pack_exc;
  cls_t        cls_a, cls_b, cls_nx;

  always_comb begin
    cls_a = classify(a_r);
    cls_b = classify(b_r);
    if (cls_a == NAN || cls_b == NAN ||
        (cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO))
      cls_nx = NAN;
    else if (cls_a == INF || cls_b == INF)
      cls_nx = INF;
    else if (cls_a == ZERO || cls_b == ZERO)
      cls_nx = ZERO;
    else
      cls_nx = NORM;
  end

  always_comb begin
    acc_nx = acc;
    for (int i = 0; i < RADIX_BITS; i++)
      if (mplier[i]) acc_nx = acc_nx + (mcand << i);
  end

  fp_round_pack u_round_pack (
    .sign      (sign_r),
    .exp_in    (exp_r),
    .prod      (acc),
    .cls       (cls_r),
    .result    (pack_res),
    .overflow  (pack_ovf),
    .underflow (pack_unf),
    .exception (pack_exc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      cls_r     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      pend_res  <= '0;
      pend_ovf  <= 1'b0;
      pend_unf  <= 1'b0;
      pend_exc  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else if (!EN) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r       <= A;
            b_r       <= B;
            busy      <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
            state     <= UNPACK;
          end
        end
        UNPACK: begin
          sign_r <= a_r[31] ^ b_r[31];
          exp_r  <= {2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} - 10'(EXP_BIAS);
          cls_r  <= cls_nx;
          mcand  <= {24'h0, 1'b1, a_r[22:0]};
          mplier <= {1'b1, b_r[22:0]};
          acc    <= '0;
          cnt    <= '0;
`ifdef FPMUL_EARLY_SPECIAL_EN
          state  <= (cls_nx != NORM) ? ROUND : MUL;
`else
          state  <= MUL;
`endif
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier >> RADIX_BITS;
          cnt    <= cnt + 5'd1;
          if (cnt == LAST) state <= ROUND;
        end
        ROUND: begin
          pend_res <= pack_res;
          pend_ovf <= pack_ovf;
          pend_unf <= pack_unf;
          pend_exc <= pack_exc;
          state    <= DONE;
        end
        DONE: begin
          result    <= pend_res;
          overflow  <= pend_ovf;
          underflow <= pend_unf;
          exception <= pend_exc;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// tb/tb_fp_seq_multiplier.sv - directed self-checking bench for fp_seq_multiplier
module tb_fp_seq_multiplier;

  localparam int RADIX_BITS = 1;
  localparam int LAT = 24 / RADIX_BITS + 3;
`ifdef FPMUL_EARLY_SPECIAL_EN
  localparam int SPEC_LAT = 3;
`else
  localparam int SPEC_LAT = LAT;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, overflow, underflow, exception;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_seq_multiplier #(.RADIX_BITS(RADIX_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (en),
    .start     (start),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception)
  );

  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x;
    b = y;
    en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!done && cycles < 100);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, overflow, underflow, exception} !== 5'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: busy/done/flags=%b result=%h, required 00000 and 00000000",
               {busy, done, overflow, underflow, exception}, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: busy/done=%b result=%h, required 00 and 00000000",
               {busy, done}, result);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [4] = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h40400000};
    logic [31:0] vb [4] = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'hC0400000};
    logic [31:0] vr [4] = '{32'h40400000, 32'hBFC00000, 32'h3F800002, 32'hC1100000};
    int c;
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i]);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL arith_busy[%0d]: busy=%b, required 1", i, busy);
      end
      wait_done(c);
      checks++;
      if (c != LAT) begin
        errors++;
        $display("FAIL arith_latency[%0d]: %0d cycles, required %0d", i, c, LAT);
      end
      checks++;
      if (result !== vr[i] || {overflow, underflow, exception} !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL arith_result[%0d]: result=%h flags=%b busy=%b, required %h 000 0",
                 i, result, {overflow, underflow, exception}, busy, vr[i]);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    int c;
    launch(32'h7F000000, 32'h40000000);
    wait_done(c);
    checks++;
    if (result !== 32'h7F800000 || {overflow, underflow, exception} !== 3'b100) begin
      errors++;
      $display("FAIL overflow: result=%h flags=%b, required 7f800000 100",
               result, {overflow, underflow, exception});
    end
    launch(32'h00800000, 32'h00800000);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear_on_start: overflow=%b, required 0", overflow);
    end
    wait_done(c);
    checks++;
    if (result !== 32'h00000000 || {overflow, underflow, exception} !== 3'b010 || c != LAT) begin
      errors++;
      $display("FAIL underflow: result=%h flags=%b cycles=%0d, required 00000000 010 %0d",
               result, {overflow, underflow, exception}, c, LAT);
    end
  endtask

  task automatic test_special();
    logic [31:0] va [3] = '{32'h00000000, 32'hFF800000, 32'h00000000};
    logic [31:0] vb [3] = '{32'h7F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] vr [3] = '{32'h7FC00000, 32'hFF800000, 32'h00000000};
    logic [2:0]  vf [3] = '{3'b001, 3'b001, 3'b000};
    int c;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i]);
      wait_done(c);
      checks++;
      if (c != SPEC_LAT) begin
        errors++;
        $display("FAIL special_latency[%0d]: %0d cycles, required %0d", i, c, SPEC_LAT);
      end
      checks++;
      if (result !== vr[i] || {overflow, underflow, exception} !== vf[i]) begin
        errors++;
        $display("FAIL special_result[%0d]: result=%h flags=%b, required %h %b",
                 i, result, {overflow, underflow, exception}, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_abort_en();
    int seen;
    launch(32'h3FC00000, 32'h40000000);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || result !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_en: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    seen = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", seen);
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    int c;
    launch(32'h3FC00000, 32'h40000000);
    wait_done(c);
    launch(32'hC0400000, 32'h3F000000);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    a = 32'h3FC00000;
    b = 32'h40000000;
    en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'hC0400000;
    b = 32'h3F000000;
    wait_done(c);
    checks++;
    if (c != LAT || result !== 32'h40400000) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d result=%h, required %0d 40400000", c, result, LAT);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'h40400000) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b result=%h, required 1 0 40400000", busy, done, result);
    end
    wait_done(c);
    checks++;
    if (c != LAT || result !== 32'hBFC00000) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d result=%h, required %0d bfc00000", c, result, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_abort_en();
    test_overflow_underflow();
    test_special();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
